// File: rtl/ramd32_fifo_ctrl_pkg.sv
// Shared constants and status encoding for the 32-deep ramd32 FIFO controller.
package ramd32_fifo_ctrl_pkg;

    localparam int FIFO_DEPTH = 32;
    localparam int PTR_W      = 5;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } status_e;

    function automatic status_e status_of(input logic [PTR_W:0] cnt);
        if (cnt == '0)
            return EMPTY;
        else if (cnt == (PTR_W + 1)'(FIFO_DEPTH))
            return FULL;
        else
            return PARTIAL;
    endfunction

endpackage

// File: rtl/ramd32_fifo_ctrl_ramd32xn.sv
// ramd32x1: 32x1 dual-address distributed RAM slice (sync write, async read).
// ramd32xn: WIDTH slices sharing write enable and both address buses.
module ramd32x1 (
    input  logic di,
    input  logic wck,
    input  logic we,
    input  logic a0w,
    input  logic a1w,
    input  logic a2w,
    input  logic a3w,
    input  logic a4w,
    input  logic a0r,
    input  logic a1r,
    input  logic a2r,
    input  logic a3r,
    input  logic a4r,
    output logic dout
);
    logic mem [0:31];

    always_ff @(posedge wck) begin
        if (we)
            mem[{a4w, a3w, a2w, a1w, a0w}] <= di;
    end

    assign dout = mem[{a4r, a3r, a2r, a1r, a0r}];
endmodule

module ramd32xn
    import ramd32_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [PTR_W-1:0] raddr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    for (genvar i = 0; i < WIDTH; i++) begin : g_slice
        ramd32x1 u_bit (
            .di   (wdata[i]),
            .wck  (clk),
            .we   (we),
            .a0w  (waddr[0]),
            .a1w  (waddr[1]),
            .a2w  (waddr[2]),
            .a3w  (waddr[3]),
            .a4w  (waddr[4]),
            .a0r  (raddr[0]),
            .a1r  (raddr[1]),
            .a2r  (raddr[2]),
            .a3r  (raddr[3]),
            .a4r  (raddr[4]),
            .dout (rdata[i])
        );
    end
endmodule

// File: rtl/ramd32_fifo_ctrl.sv
// 32-entry first-word-fall-through FIFO controller over ramd32x1 slices.
// Optional sticky overflow/underflow flags under `RAMD32_FIFO_ERR_EN.
module ramd32_fifo_ctrl
    import ramd32_fifo_ctrl_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int AFULL_LVL = 28
) (
    input  logic             clk,
    input  logic             mr_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic             afull,
    output logic [5:0]       count,
`ifdef RAMD32_FIFO_ERR_EN
    output logic             ovf,
    output logic             unf,
`endif
    output status_e          status
);
    logic             run_q;
    logic             push;
    logic             pop;
    logic             we;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [5:0]       count_nx;
    status_e          status_nx;

    // Release of mr_n takes effect one edge later, so the first push lands on the second edge.
    always_ff @(posedge clk or negedge mr_n) begin
        if (!mr_n)
            run_q <= 1'b0;
        else
            run_q <= 1'b1;
    end

    always_comb begin
        push      = wr_en & ~full & run_q;
        pop       = rd_en & ~empty & run_q;
        count_nx  = count;
        case ({push, pop})
            2'b10:   count_nx = count + 6'd1;
            2'b01:   count_nx = count - 6'd1;
            default: count_nx = count;
        endcase
        status_nx = status_of(count_nx);
    end

    assign we = push & mr_n;

    always_ff @(posedge clk or negedge mr_n) begin
        if (!mr_n) begin
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
            status <= EMPTY;
            empty  <= 1'b1;
            full   <= 1'b0;
            afull  <= 1'b0;
        end else begin
            if (push)
                wptr <= wptr + 5'd1;
            if (pop)
                rptr <= rptr + 5'd1;
            count  <= count_nx;
            status <= status_nx;
            empty  <= (status_nx == EMPTY);
            full   <= (status_nx == FULL);
            afull  <= (count_nx >= 6'(AFULL_LVL));
        end
    end

`ifdef RAMD32_FIFO_ERR_EN
    always_ff @(posedge clk or negedge mr_n) begin
        if (!mr_n) begin
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            if (wr_en & full)
                ovf <= 1'b1;
            if (rd_en & empty)
                unf <= 1'b1;
        end
    end
`endif

    ramd32xn #(.WIDTH(WIDTH)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wptr),
        .raddr (rptr),
        .wdata (wr_data),
        .rdata (rd_data)
    );
endmodule

// File: doc/ramd32_fifo_ctrl.md
RAMD32_FIFO_CTRL -- requirements
Module: ramd32_fifo_ctrl

Interface
REQ-001 Parameter WIDTH, default 8: data width, i.e. the number of ramd32x1 bit-slices instantiated.
REQ-002 Parameter AFULL_LVL, default 28: occupancy at or above which afull is asserted; legal range 1..31.
REQ-003 clk  input  1  single clock for all logic and for every RAM write port; rising edge.
REQ-004 mr_n  input  1  master reset; asynchronous assertion, active-low.
REQ-005 wr_en  input  1  push request.
REQ-006 wr_data  input  WIDTH  push data.
REQ-007 rd_en  input  1  pop request.
REQ-008 rd_data  output  WIDTH  head-of-queue data, first-word-fall-through.
REQ-009 full  output  1  occupancy = 32.
REQ-010 empty  output  1  occupancy = 0.
REQ-011 afull  output  1  occupancy >= AFULL_LVL.
REQ-012 count  output  6  current occupancy, range 0..32.

Function
REQ-013 Storage SHALL be WIDTH ramd32x1 instances sharing clk, we, the write address (5 bits) and the read address (5 bits).
REQ-014 The write pointer wptr (5 bits) SHALL drive a0w..a4w; the read pointer rptr (5 bits) SHALL drive a0r..a4r; we = push.
REQ-015 push = wr_en & ~full; a push writes wr_data at wptr on the clk edge, then wptr increments mod 32 (31 -> 0).
REQ-016 pop = rd_en & ~empty; on the clk edge rptr increments mod 32.
REQ-017 rd_data SHALL be the combinational RAM output at rptr; it is valid whenever empty = 0 and undefined otherwise.
REQ-018 count SHALL be a 6-bit register: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-019 full, empty and afull SHALL be registered and updated in the same edge as count; no output is combinational from wr_en or rd_en.
REQ-020 Status states: EMPTY (count = 0), PARTIAL (1..31), FULL (32); transitions only by ±1 per cycle.
REQ-021 Push while full SHALL be ignored even if rd_en is high that cycle: only the pop occurs, count 32 -> 31.
REQ-022 Pop while empty SHALL be ignored even if wr_en is high: only the push occurs, count 0 -> 1.
REQ-023 Data pushed into an empty FIFO SHALL appear on rd_data and empty SHALL fall in the cycle after the push edge (latency 1).
REQ-024 Simultaneous push and pop in PARTIAL SHALL keep count and status unchanged and advance both pointers.

Reset
REQ-025 mr_n low SHALL asynchronously clear wptr, rptr and count to 0, set empty = 1, and clear full and afull to 0.
REQ-026 Release of mr_n SHALL be synchronised to clk; the first push is accepted on the second clk edge after deassertion.
REQ-027 Reset mid-operation SHALL discard all queued entries; RAM contents are not cleared, and the RAM mr inputs are not used.
REQ-028 we SHALL be forced to 0 while mr_n is low.

Configuration
REQ-029 Macro RAMD32_FIFO_ERR_EN, when defined, SHALL add two outputs, ovf and unf (1 bit each), with these behaviours:
- ovf sets when wr_en & full.
- unf sets when rd_en & empty.
- Both are sticky until reset and reset to 0.
REQ-030 Without RAMD32_FIFO_ERR_EN, the ports ovf and unf and their logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 A shared package SHALL hold the constants FIFO_DEPTH = 32 and PTR_W = 5 and the status enum (EMPTY, PARTIAL, FULL).
REQ-032 One sub-module, ramd32xn, SHALL wrap the WIDTH ramd32x1 bit-slices behind a bus interface; all control stays in ramd32_fifo_ctrl.

Verification
REQ-033 Reset, then push 0x00..0x1F (32 words) -> full = 1 after the 32nd edge, afull = 1 from count 28, count = 32.
REQ-034 From full, pop 32 words -> rd_data reads 0x00..0x1F in order, empty = 1 after the last edge, count = 0.
REQ-035 From full, wr_en = rd_en = 1 with wr_data = 0xAA -> count = 31 and 0xAA is never read back.
REQ-036 From count = 5, 40 cycles with wr_en = rd_en = 1 -> count stays 5, pointers wrap past 31, and data order is preserved.
REQ-037 Push 3 words, assert mr_n low mid-cycle -> outputs clear immediately (empty = 1, count = 0), and a subsequent pop shows new data only.
REQ-038 With RAMD32_FIFO_ERR_EN: pop when empty -> unf = 1 and held; push when full -> ovf = 1; both clear only on reset.
